// File: rtl/rle_pkg.sv
// rle_pkg: shared constants, entry layout, FSM state type and byte builders for rle_run_packer.
// RLE_PACK_CHECKSUM_EN adds the CSUM state to the enum.
package rle_pkg;

  localparam logic [7:0]  RLE_HDR = 8'hFF;
  localparam logic [7:0]  RLE_FTR = 8'hFE;
  localparam int unsigned ENTRY_W = 12;
  localparam int unsigned END_BIT = 11;
  localparam int unsigned PIX_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RUN_HI,
    ST_RUN_LO,
    ST_FOOT
`ifdef RLE_PACK_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_e;

  // Run bytes keep bit7 clear so they can never alias the frame markers.
  function automatic logic [7:0] run_hi(input logic pix, input logic [5:0] len_hi);
    return {1'b0, pix, len_hi};
  endfunction

  function automatic logic [7:0] run_lo(input logic [3:0] len_lo);
    return {4'b0000, len_lo};
  endfunction

endpackage

// File: rtl/rle_sync_fifo.sv
// rle_sync_fifo: single-clock FIFO with registered level and a zero-latency head peek.
module rle_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  // A push at full is still taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != (AW + 1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/rle_run_packer.sv
// rle_run_packer: queues {pix,len} runs and serialises them as 0xFF ... 0xFE framed bytes.
// Define RLE_PACK_CHECKSUM_EN to append a 7-bit XOR checksum of the run bytes after the footer.
module rle_run_packer
  import rle_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LEN_W = 10
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   run_valid,
  input  logic                   run_pix,
  input  logic [LEN_W-1:0]       run_len,
  input  logic                   im_end,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic               pending_end_q, pending_end_d;
  logic               overflow_q, overflow_d;
  logic [ENTRY_W-1:0] head, push_data;
  logic               fifo_empty, push_en, pop;
  logic               run_req, run_push, end_req, hdr_acc;

  assign run_req  = run_valid && (run_len != '0);
  assign run_push = run_req && (fifo_level < LW'(DEPTH - 1));
  assign end_req  = im_end || pending_end_q;
  assign hdr_acc  = tx_valid && tx_ready && (state_q == ST_HDR);

  // Runs stop one slot short of full so an end marker always finds room;
  // an end colliding with a run push waits one cycle in pending_end.
  always_comb begin
    push_en       = 1'b0;
    push_data     = '0;
    pending_end_d = pending_end_q;
    overflow_d    = overflow_q;
    if (run_push) begin
      push_en       = 1'b1;
      push_data     = {1'b0, run_pix, run_len};
      pending_end_d = end_req;
    end else if (end_req) begin
      if ((fifo_level != LW'(DEPTH)) || pop) begin
        push_en       = 1'b1;
        push_data     = {1'b1, {(ENTRY_W - 1){1'b0}}};
        pending_end_d = 1'b0;
      end else begin
        pending_end_d = 1'b1;
      end
    end
    if (run_req && !run_push) overflow_d = 1'b1;
    else if (hdr_acc)         overflow_d = 1'b0;
  end

  rle_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (reset_n),
    .push_i (push_en),
    .data_i (push_data),
    .pop_i  (pop),
    .head_o (head),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

`ifdef RLE_PACK_CHECKSUM_EN
  logic [6:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_HDR;
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = RLE_HDR;
        if (tx_ready) state_d = ST_RUN_HI;
      end
      ST_RUN_HI: begin
        if (!fifo_empty) begin
          if (head[END_BIT]) begin
            pop     = 1'b1;
            state_d = ST_FOOT;
          end else begin
            tx_valid = 1'b1;
            tx_data  = run_hi(head[PIX_BIT], head[9:4]);
            if (tx_ready) state_d = ST_RUN_LO;
          end
        end
      end
      ST_RUN_LO: begin
        tx_valid = 1'b1;
        tx_data  = run_lo(head[3:0]);
        if (tx_ready) begin
          pop     = 1'b1;
          state_d = ST_RUN_HI;
        end
      end
      ST_FOOT: begin
        tx_valid = 1'b1;
        tx_data  = RLE_FTR;
`ifdef RLE_PACK_CHECKSUM_EN
        if (tx_ready) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, csum_q};
`endif
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RLE_PACK_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (hdr_acc) begin
      csum_d = '0;
    end else if (tx_valid && tx_ready &&
                 ((state_q == ST_RUN_HI) || (state_q == ST_RUN_LO))) begin
      csum_d = csum_q ^ tx_data[6:0];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pending_end_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_end_q <= pending_end_d;
      overflow_q    <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_rle_run_packer.sv
// tb_rle_run_packer: directed and randomized checks of rle_run_packer against a frame-level byte model.
module tb_rle_run_packer;

  localparam int unsigned DEPTH = 16;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_valid = 1'b0;
  logic       run_pix = 1'b0;
  logic [9:0] run_len = '0;
  logic       im_end = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       overflow;
  logic [4:0] fifo_level;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [7:0] exp_q[$];
  bit         in_frame = 1'b0;
  logic [6:0] m_x = '0;

  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  rle_run_packer #(
    .DEPTH(DEPTH),
    .LEN_W(10)
  ) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .run_valid (run_valid),
    .run_pix   (run_pix),
    .run_len   (run_len),
    .im_end    (im_end),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: each queued entry appends its bytes to the expected link stream.
  task automatic m_push(input bit is_end, input bit pix, input int len);
    int hi, lo;
    if (!in_frame) begin
      exp_q.push_back(8'hFF);
      in_frame = 1'b1;
      m_x = '0;
    end
    if (is_end) begin
      exp_q.push_back(8'hFE);
`ifdef RLE_PACK_CHECKSUM_EN
      exp_q.push_back({1'b0, m_x});
`endif
      in_frame = 1'b0;
    end else begin
      hi = pix * 64 + len / 16;
      lo = len % 16;
      exp_q.push_back(8'(hi));
      exp_q.push_back(8'(lo));
      m_x = m_x ^ 7'(hi) ^ 7'(lo);
    end
  endtask

  task automatic drive(input bit rv, input bit pix, input int len, input bit e);
    run_valid = rv;
    run_pix   = pix;
    run_len   = 10'(len);
    im_end    = e;
    @(posedge CLK);
    #1;
    run_valid = 1'b0;
    run_pix   = 1'b0;
    run_len   = '0;
    im_end    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int unsigned t;
    t = 0;
    while ((exp_q.size() != 0 || tx_valid) && t < 2000) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
    check({tag, "_idle"}, {31'b0, tx_valid}, 0);
    check({tag, "_level"}, {27'b0, fifo_level}, 0);
  endtask

  // Link monitor: consumes accepted bytes and checks hold-while-stalled.
  always @(negedge CLK) begin
    if (reset_n) begin
      if (stall_q) check("hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, stall_data});
      if (tx_valid && tx_ready) begin
        check("byte_avail", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      end
      stall_q    <= tx_valid && !tx_ready;
      stall_data <= tx_data;
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    bit          rv, e, pix, skip;
    int          len;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", {31'b0, tx_valid}, 0);
    check("rst_data", {24'b0, tx_data}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_level", {27'b0, fifo_level}, 0);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    @(posedge CLK);
    #1;

    // Two runs and an end; header appears two cycles after the first push.
    drive(1, 1, 5, 0);
    m_push(0, 1, 5);
    check("lat_c1_valid", {31'b0, tx_valid}, 0);
    @(posedge CLK);
    #1;
    check("lat_c2_valid", {31'b0, tx_valid}, 1);
    check("lat_c2_data", {24'b0, tx_data}, 32'hFF);
    drive(1, 0, 300, 0);
    m_push(0, 0, 300);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    drain("t1");

    // Run and end in the same cycle.
    drive(1, 1, 1023, 1);
    m_push(0, 1, 1023);
    m_push(1, 0, 0);
    drain("t2");

    // Header held while the link stalls.
    tx_ready = 1'b0;
    drive(1, 0, 7, 0);
    m_push(0, 0, 7);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    t = 0;
    while (!tx_valid && t < 20) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("t3_valid_rise", {31'b0, tx_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check("t3_hold_ff", {23'b0, tx_valid, tx_data}, 32'h1FF);
    end
    tx_ready = 1'b1;
    drain("t3");

    // Overflow: runs fill DEPTH-1 slots, the end marker takes the last one.
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pix = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 1023));
      drive(1, pix, len, 0);
      if (i < DEPTH - 1) m_push(0, pix, len);
    end
    check("t4_level_runs", {27'b0, fifo_level}, DEPTH - 1);
    check("t4_ovf_set", {31'b0, overflow}, 1);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    check("t4_level_end", {27'b0, fifo_level}, DEPTH);
    check("t4_ovf_kept", {31'b0, overflow}, 1);
    tx_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("t4_ovf_clear", {31'b0, overflow}, 0);
    drain("t4");

    // Bare ends and zero-length runs.
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    drain("t5");

    // Reset while the low run byte is on the link.
    tx_ready = 1'b0;
    drive(1, 1, 'h155, 0);
    m_push(0, 1, 'h155);
    drive(1, 0, 'h2AA, 0);
    m_push(0, 0, 'h2AA);
    t = 0;
    while (!tx_valid && t < 20) begin
      @(posedge CLK);
      #1;
      t++;
    end
    tx_ready = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    tx_ready = 1'b0;
    check("t6_in_lo", {23'b0, tx_valid, tx_data}, 32'h105);
    reset_n = 1'b0;
    exp_q.delete();
    in_frame = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, tx_valid}, 0);
    check("t6_rst_level", {27'b0, fifo_level}, 0);
    @(posedge CLK);
    #1;
    check("t6_edge_valid", {31'b0, tx_valid}, 0);
    check("t6_edge_level", {27'b0, fifo_level}, 0);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    drive(1, 0, 9, 0);
    m_push(0, 0, 9);
    drive(0, 0, 0, 1);
    m_push(1, 0, 0);
    drain("t6");

    // Randomized traffic with a randomly stalling link.
    skip = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rv  = !skip && ($urandom_range(0, 5) == 0);
      e   = !skip && ($urandom_range(0, 29) == 0);
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
      pix = 1'($urandom_range(0, 1));
      tx_ready = ($urandom_range(0, 9) < 7);
      skip = rv && e;
      drive(rv, pix, len, e);
      if (rv && len != 0) m_push(0, pix, len);
      if (e) m_push(1, 0, 0);
    end
    tx_ready = 1'b1;
    @(posedge CLK);
    #1;
    if (in_frame) begin
      drive(0, 0, 0, 1);
      m_push(1, 0, 0);
    end
    drain("t7");
    check("t7_ovf", {31'b0, overflow}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
